// File: rtl/dual_rail_sync_rx.sv
// Clocked receiver for four-phase return-to-zero dual-rail channels.
// Synchronizes the rails, acknowledges each codeword and queues it in a show-ahead FIFO.
module dual_rail_sync_rx #(
  parameter int unsigned W           = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*W-1:0]           din,
  output logic                     ack_out,
  output logic [W-1:0]             dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, ACK} state_e;

  logic [SYNC_STAGES-1:0][2*W-1:0] sync_q;
  logic [2*W-1:0]                  s;
  logic                            complete_c, null_c, illegal_c;
  logic [W-1:0]                    word_c;

  state_e          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q;
  logic            push_c, pop_c, full_c;
  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  // Rail synchronizer chain; every rail is independently double-flopped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Codeword classification and decode
  always_comb begin
    complete_c = 1'b1;
    null_c     = 1'b1;
    illegal_c  = 1'b0;
    word_c     = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (s[2*i+1] && s[2*i])       illegal_c  = 1'b1;
      if (s[2*i+1] == s[2*i])       complete_c = 1'b0;
      if (s[2*i+1] || s[2*i])       null_c     = 1'b0;
      word_c[i] = s[2*i+1];
    end
  end

  assign full_c = (count_q == CW'(DEPTH));
  assign pop_c  = dout_valid && dout_ready;

  // Handshake state, acknowledge and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_q | illegal_c;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (complete_c && !illegal_c && !full_c) state_d = ACK;
      ACK:  if (null_c)                              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d  = ack_q;
    push_c = 1'b0;
    case (state_q)
      IDLE: if (complete_c && !illegal_c && !full_c) begin
        ack_d  = 1'b1;
        push_c = 1'b1;
      end
      ACK:  if (null_c) ack_d = 1'b0;
      default: ack_d = 1'b0;
    endcase
  end

  // FIFO pointers and occupancy; push admission uses pre-edge fullness
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= word_c;
  end

  assign dout_valid = (count_q != '0);
  assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign ack_out    = ack_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dual_rail_sync_rx.sv
// Self-checking bench for dual_rail_sync_rx: sender model plus an ordered-word scoreboard.
module tb_dual_rail_sync_rx;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*W-1:0] din;
  logic          ack_out;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [2:0]    count;
  logic          err;

  int checks = 0;
  int errors = 0;
  int max_count = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  dual_rail_sync_rx #(.W(16), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .din(din), .ack_out(ack_out), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  // Consumer-side monitor: every word actually popped, in order
  always @(posedge clk) begin
    if (!rst && dout_valid && dout_ready) got_q.push_back(dout);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 2000000)", $time);
    $fatal(1);
  end

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] w);
    logic [2*W-1:0] e;
    for (int i = 0; i < int'(W); i++) e[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (int'(count) > max_count) max_count = int'(count);
  endtask

  // Four-phase sender: data, wait ack high, spacer, wait ack low
  task automatic send_word(input logic [W-1:0] w);
    int n;
    din = enc(w);
    n = 0;
    while (!ack_out && n < 300) begin step(); n++; end
    checks++;
    if (!ack_out) begin
      errors++;
      $display("FAIL send_ack_rise: ack_out=%0b required 1 for word %h", ack_out, w);
    end
    exp_q.push_back(w);
    din = '0;
    n = 0;
    while (ack_out && n < 300) begin step(); n++; end
    checks++;
    if (ack_out) begin
      errors++;
      $display("FAIL send_ack_fall: ack_out=%0b required 0 for word %h", ack_out, w);
    end
  endtask

  task automatic drain();
    int n;
    dout_ready = 1'b1;
    n = 0;
    while (dout_valid && n < 50) begin step(); n++; end
    dout_ready = 1'b0;
  endtask

  task automatic compare_queues(input string tag);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d words required %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_word%0d: got %h required %h", tag, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    int n;
    dout_ready = 1'b0;
    send_word(16'h1111);
    din = enc(16'h2222);
    n = 0;
    while (!ack_out && n < 50) begin step(); n++; end
    checks++;
    if (ack_out !== 1'b1 || count !== 3'd2) begin
      errors++;
      $display("FAIL reset_setup: ack_out=%0b count=%0d required 1 and 2", ack_out, count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ack_out !== 1'b0 || count !== 3'd0 || dout_valid !== 1'b0 || err !== 1'b0 || dout !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: ack=%0b count=%0d valid=%0b err=%0b dout=%h required 0 0 0 0 0000",
               ack_out, count, dout_valid, err, dout);
    end
    din = '0;
    step();
    rst = 1'b0;
    repeat (4) step();
    checks++;
    if (ack_out !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: ack=%0b count=%0d required 0 0", ack_out, count);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single();
    logic [2:0] lat_ack;
    dout_ready = 1'b0;
    din = enc(16'hA5C3);
    lat_ack = '0;
    for (int i = 0; i < 3; i++) begin step(); lat_ack[i] = ack_out; end
    checks++;
    if (lat_ack !== 3'b100) begin
      errors++;
      $display("FAIL single_rise_latency: ack per edge=%b required 100", lat_ack);
    end
    checks++;
    if (dout !== 16'hA5C3 || count !== 3'd1 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_data: dout=%h count=%0d valid=%0b required a5c3 1 1", dout, count, dout_valid);
    end
    exp_q.push_back(16'hA5C3);
    din = '0;
    for (int i = 0; i < 3; i++) begin step(); lat_ack[i] = ack_out; end
    checks++;
    if (lat_ack !== 3'b011) begin
      errors++;
      $display("FAIL single_fall_latency: ack per edge=%b required 011", lat_ack);
    end
    drain();
    compare_queues("single");
  endtask

  task automatic test_skew();
    logic [W-1:0] w;
    logic [2*W-1:0] e;
    int early;
    w = W'($urandom);
    e = enc(w);
    dout_ready = 1'b0;
    din = '0;
    early = 0;
    for (int i = 0; i < int'(W); i++) begin
      din[2*i +: 2] = e[2*i +: 2];
      step();
      if (ack_out) early++;
    end
    step();
    if (ack_out) early++;
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL skew_early_ack: early ack edges=%0d required 0", early);
    end
    step();
    checks++;
    if (ack_out !== 1'b1) begin
      errors++;
      $display("FAIL skew_ack: ack_out=%0b required 1", ack_out);
    end
    exp_q.push_back(w);
    repeat (6) step();
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL skew_single_push: count=%0d required 1", count);
    end
    din = '0;
    repeat (4) step();
    drain();
    compare_queues("skew");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w5;
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(W'($urandom));
    w5 = W'($urandom);
    din = enc(w5);
    repeat (6) step();
    checks++;
    if (count !== 3'd4 || ack_out !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: count=%0d ack=%0b required 4 0", count, ack_out);
    end
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    checks++;
    if (count !== 3'd3 || ack_out !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_edge: count=%0d ack=%0b required 3 0", count, ack_out);
    end
    step();
    checks++;
    if (count !== 3'd4 || ack_out !== 1'b1) begin
      errors++;
      $display("FAIL full_refill: count=%0d ack=%0b required 4 1", count, ack_out);
    end
    exp_q.push_back(w5);
    din = '0;
    repeat (4) step();
    drain();
    compare_queues("full");
  endtask

  task automatic test_illegal();
    logic [W-1:0] w;
    logic [2*W-1:0] e;
    w = W'($urandom);
    e = enc(w);
    dout_ready = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pre_err: err=%0b required 0", err);
    end
    e[7:6] = 2'b11;
    din = e;
    repeat (5) step();
    checks++;
    if (err !== 1'b1 || ack_out !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL illegal_reject: err=%0b ack=%0b count=%0d required 1 0 0", err, ack_out, count);
    end
    din = enc(w);
    repeat (3) step();
    checks++;
    if (ack_out !== 1'b1 || count !== 3'd1 || err !== 1'b1 || dout !== w) begin
      errors++;
      $display("FAIL illegal_recover: ack=%0b count=%0d err=%0b dout=%h required 1 1 1 %h",
               ack_out, count, err, dout, w);
    end
    exp_q.push_back(w);
    din = '0;
    repeat (4) step();
    drain();
    compare_queues("illegal");
  endtask

  task automatic test_throughput();
    dout_ready = 1'b1;
    max_count = 0;
    for (int i = 0; i < 10; i++) send_word(W'(i));
    repeat (4) step();
    checks++;
    if (max_count > 1) begin
      errors++;
      $display("FAIL thru_count: max count=%0d required <= 1", max_count);
    end
    dout_ready = 1'b0;
    compare_queues("thru");
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send_word(W'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          dout_ready = ($urandom_range(0, 2) == 0);
        end
      end
    join
    drain();
    compare_queues("random");
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    dout_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    test_reset();
    test_single();
    test_skew();
    test_backpressure();
    test_throughput();
    test_random();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_rail_sync_rx.md
Name: dual_rail_sync_rx

Overview:
Clocked receiving endpoint for the CPU's four-phase, return-to-zero dual-rail channels. It captures a W-bit dual-rail codeword from an asynchronous stage and acknowledges it back to that stage. Each accepted word is delivered to synchronous logic through a show-ahead FIFO with a valid/ready interface. It closes the handshake loop that dual-rail producers (memory data demux, instruction buffer) drive as transmitters, and lets a clocked monitor or peripheral consume their output.

Parameters:
W, 16, data bits per codeword; the dual-rail bus is 2*W wires.
DEPTH, 4, FIFO entries; power of two, at least 2.
SYNC_STAGES, 2, synchronizer flops per rail; at least 2.

Ports:
clk  input  1  sole clock
rst  input  1  asynchronous reset, active-high
din  input  2*W  dual-rail data; pair i = din[2i+1:2i]
ack_out  output  1  four-phase acknowledge to the sending async stage
dout  output  W  FIFO head word
dout_valid  output  1  FIFO not empty
dout_ready  input  1  consumer pops the head word on a clk edge when dout_valid=1
count  output  $clog2(DEPTH)+1  FIFO occupancy
err  output  1  sticky illegal-code flag

Behaviour:
- One clock; reset is asynchronous and active-high.
- Pair encoding: 2'b01 = logic 0, 2'b10 = logic 1, 2'b00 = null (spacer), 2'b11 = illegal.
- Every rail passes through SYNC_STAGES flops (reset 0). The synchronized bus is s.
- complete(s): every pair is 01 or 10. null(s): every pair is 00. illegal(s): any pair is 11.
- Decoded word: bit i = s[2i+1].
- Reset (asynchronous, immediate): ack_out=0, state=IDLE, FIFO emptied (count=0, dout_valid=0, dout=0), err=0, sync flops cleared.
- FSM, ack_out registered:
  - IDLE: on an edge where complete(s), !illegal(s) and FIFO not full, push the decoded word, set ack_out=1 and go to ACK.
  - IDLE with complete(s) and FIFO full: hold IDLE with ack_out=0. This backpressures the sender, which keeps data asserted until a slot frees.
  - ACK: on an edge where null(s), set ack_out=0 and go to IDLE. Partial nulls hold ACK.
- Latency: a din change reaches s after SYNC_STAGES edges. ack_out rises on the next edge, SYNC_STAGES+1 edges after the final rail settles. The word is visible on dout on that same edge if the FIFO was empty.
- Exactly one push per four-phase cycle. A codeword held for many cycles is never pushed twice.
- illegal(s) in any state sets err=1, which stays set until reset. In IDLE the word is not accepted while illegal(s); the FSM waits.
- FIFO:
  - Pop occurs when dout_valid & dout_ready.
  - Push is evaluated against pre-edge fullness. A pop on the same edge does not permit a push into a full FIFO.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - dout_ready is ignored when empty.
- Reset in mid-handshake drops ack_out at once and discards FIFO contents. If the sender is still holding a codeword when rst deasserts, that word is accepted again. This duplicate is accepted behaviour.

Test Plan:
- Reset: assert rst with ack_out=1 and count=2 -> ack_out=0, count=0, dout_valid=0 and err=0 without any clk edge.
- Single word, W=16: drive din encoding 16'hA5C3, hold dout_ready=0 -> ack_out rises 3 edges after din settles; dout=16'hA5C3, count=1. Drive din=0 -> ack_out falls 3 edges later.
- Skewed arrival: settle pairs one per cycle over 16 cycles -> ack_out stays 0 until the last pair is synchronized; exactly one push.
- Full backpressure, DEPTH=4: send 5 words with dout_ready=0 -> count=4, 5th ack_out stays 0. Pulse dout_ready for one cycle -> on the next edge the 5th word is pushed, count returns to 4, and the order is preserved on pops.
- Illegal code: force pair 3 to 11 -> err=1, no push, ack_out=0. Correct the pair -> the word is accepted and err remains 1.
- Throughput and wrap: 10 words 0x0000..0x0009 with dout_ready=1 -> dout sequence in order across pointer wrap, count never exceeds 1, no duplicates.
